// File: rtl/reg_load_sequencer.sv
// rtl/reg_load_sequencer.sv - register-bank load sequencer with optional readback verify
module reg_load_sequencer #(
   parameter int WIDTH     = 4,
   parameter int NUM_REGS  = 4,
   parameter int SETUP_CYC = 1,
   parameter int VERIFY    = 1,
   localparam int SELW     = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1
) (
   input  logic                      clk,
   input  logic                      reset,
   input  logic                      req_valid,
   output logic                      req_ready,
   input  logic [SELW-1:0]           req_dst,
   input  logic [WIDTH-1:0]          req_data,
   output logic [WIDTH-1:0]          bus_out,
   output logic [NUM_REGS-1:0]       ld_n,
   input  logic [NUM_REGS*WIDTH-1:0] rb_data,
   output logic                      busy,
   output logic                      done,
   output logic                      err
);

   localparam logic [1:0] IDLE   = 2'd0;
   localparam logic [1:0] SETUP  = 2'd1;
   localparam logic [1:0] STROBE = 2'd2;
   localparam logic [1:0] CHECK  = 2'd3;

   // Counter preload: SETUP lasts SETUP_CYC cycles, counting down to zero.
   localparam logic [3:0]  SETUP_LOAD = (SETUP_CYC > 0) ? 4'(SETUP_CYC - 1) : 4'd0;
   localparam logic [SELW:0] NUM_REGS_X = (SELW + 1)'(NUM_REGS);

   logic [1:0]       state;
   logic [3:0]       cnt;
   logic [SELW-1:0]  dst_q;
   logic [WIDTH-1:0] rb_sel;
   logic             bad_req;
   logic             strobe_now;

   assign req_ready  = (state == IDLE) && reset;
   assign busy       = (state != IDLE);
   assign bad_req    = ({1'b0, req_dst} >= NUM_REGS_X);
   // Reset low in STROBE aborts the write immediately, not at the next edge.
   assign strobe_now = (state == STROBE) && reset;

   // Pick the readback slice of the latched destination.
   always_comb begin
      rb_sel = '0;
      for (int i = 0; i < NUM_REGS; i++) begin
         if (dst_q == SELW'(i)) rb_sel = rb_data[i*WIDTH +: WIDTH];
      end
   end

   // One-hot active-low load enable, only during STROBE.
   always_comb begin
      ld_n = '1;
      for (int i = 0; i < NUM_REGS; i++) begin
         if (strobe_now && (dst_q == SELW'(i))) ld_n[i] = 1'b0;
      end
   end

   // Transaction FSM; done/err are registered so they pulse on IDLE re-entry.
   always_ff @(posedge clk) begin
      if (!reset) begin
         state   <= IDLE;
         cnt     <= '0;
         dst_q   <= '0;
         bus_out <= '0;
         done    <= 1'b0;
         err     <= 1'b0;
      end else begin
         done <= 1'b0;
         err  <= 1'b0;
         case (state)
            IDLE: begin
               if (req_valid) begin
                  dst_q   <= req_dst;
                  bus_out <= req_data;
                  if (bad_req) begin
                     // Out-of-range destination: report and stay idle, never strobe.
                     done <= 1'b1;
                     err  <= 1'b1;
                  end else if (SETUP_CYC > 0) begin
                     state <= SETUP;
                     cnt   <= SETUP_LOAD;
                  end else begin
                     state <= STROBE;
                  end
               end
            end
            SETUP: begin
               if (cnt == 4'd0) state <= STROBE;
               else             cnt   <= cnt - 4'd1;
            end
            STROBE: begin
               if (VERIFY != 0) begin
                  state <= CHECK;
               end else begin
                  state <= IDLE;
                  done  <= 1'b1;
               end
            end
            CHECK: begin
               // Register was loaded at the edge ending STROBE, so readback is current.
               state <= IDLE;
               done  <= 1'b1;
               err   <= (rb_sel != bus_out);
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_reg_load_sequencer.sv
// tb/tb_reg_load_sequencer.sv - self-checking bench for reg_load_sequencer
module tb_reg_load_sequencer;

   logic clk = 1'b0;
   logic reset;
   always #5 clk = ~clk;

   logic       req_valid [2];
   logic [1:0] req_dst   [2];
   logic [3:0] req_data  [2];

   logic       rdy0, rdy1, busy0, busy1, done0, done1, err0, err1;
   logic [3:0] bus0, bus1, ldn0;
   logic [2:0] ldn1b;
   logic [15:0] rb0;
   logic [11:0] rb1;

   logic [3:0] regs [2][4];
   logic       fault;

   int passed = 0;
   int total  = 0;
   int cyc    = 0;
   bit chk_en = 0;

   // Instance 0: defaults. Instance 1: NUM_REGS=3, no setup, no verify.
   reg_load_sequencer #(.WIDTH(4), .NUM_REGS(4), .SETUP_CYC(1), .VERIFY(1)) dut0 (
      .clk(clk), .reset(reset), .req_valid(req_valid[0]), .req_ready(rdy0),
      .req_dst(req_dst[0]), .req_data(req_data[0]), .bus_out(bus0), .ld_n(ldn0),
      .rb_data(rb0), .busy(busy0), .done(done0), .err(err0));

   reg_load_sequencer #(.WIDTH(4), .NUM_REGS(3), .SETUP_CYC(0), .VERIFY(0)) dut1 (
      .clk(clk), .reset(reset), .req_valid(req_valid[1]), .req_ready(rdy1),
      .req_dst(req_dst[1]), .req_data(req_data[1]), .bus_out(bus1), .ld_n(ldn1b),
      .rb_data(rb1), .busy(busy1), .done(done1), .err(err1));

   assign rb0 = {regs[0][3], regs[0][2], regs[0][1], regs[0][0]};
   assign rb1 = {regs[1][2], regs[1][1], regs[1][0]};

   function automatic int ps(int i); return (i == 0) ? 1 : 0; endfunction
   function automatic int pv(int i); return (i == 0) ? 1 : 0; endfunction
   function automatic int pn(int i); return (i == 0) ? 4 : 3; endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act === exp) passed++;
      else $display("FAIL %s: got %0h expected %0h", name, act, exp);
   endtask

   // Register bank model (reg1 of instance 0 ignores loads when fault is set).
   always @(posedge clk) begin
      for (int j = 0; j < 4; j++) begin
         if (ldn0[j] == 1'b0 && !(fault && j == 1)) regs[0][j] <= bus0;
         if (j < 3 && ldn1b[j] == 1'b0) regs[1][j] <= bus1;
      end
   end

   // Transaction model: each accepted request has a fixed timeline relative to its accept edge.
   int         acc   [2];
   int         len_m [2];
   int         dst_m [2];
   bit         act_m [2];
   bit         bad_m [2];
   bit         err_m [2];
   logic [3:0] bus_m [2];

   always @(posedge clk) begin
      for (int i = 0; i < 2; i++) begin
         if (!reset) begin
            act_m[i] <= 1'b0;
            bus_m[i] <= 4'h0;
         end else if (req_valid[i] && (!act_m[i] || (cyc - acc[i] >= len_m[i]))) begin
            acc[i]   <= cyc;
            act_m[i] <= 1'b1;
            dst_m[i] <= int'(req_dst[i]);
            bus_m[i] <= req_data[i];
            bad_m[i] <= int'(req_dst[i]) >= pn(i);
            len_m[i] <= (int'(req_dst[i]) >= pn(i)) ? 1 : ps(i) + pv(i) + 2;
            err_m[i] <= (int'(req_dst[i]) >= pn(i)) ||
                        (pv(i) == 1 && fault && i == 0 && req_dst[i] == 2'd1 &&
                         regs[i][req_dst[i]] != req_data[i]);
         end
      end
      cyc    <= cyc + 1;
      chk_en <= 1'b1;
   end

   // Every-cycle comparison of all outputs against the model.
   always @(negedge clk) begin
      if (chk_en) begin
         for (int i = 0; i < 2; i++) begin
            int k;
            bit busy_e, done_e, st_e, ready_e;
            logic [3:0] ld_e;
            logic [11:0] exp_v, act_v;
            k       = cyc - acc[i];
            busy_e  = act_m[i] && k >= 1 && k < len_m[i];
            done_e  = act_m[i] && k == len_m[i];
            st_e    = act_m[i] && !bad_m[i] && k == ps(i) + 1 && reset;
            ready_e = reset && !busy_e;
            ld_e    = 4'hF;
            if (st_e) ld_e[dst_m[i]] = 1'b0;
            exp_v = {ready_e, busy_e, done_e, done_e && err_m[i], ld_e, bus_m[i]};
            if (i == 0) act_v = {rdy0, busy0, done0, err0, ldn0, bus0};
            else        act_v = {rdy1, busy1, done1, err1, 1'b1, ldn1b, bus1};
            chk($sformatf("model_c%0d_i%0d", cyc, i), 32'(act_v), 32'(exp_v));
         end
      end
   end

   task automatic go(input int i, input logic [1:0] d, input logic [3:0] v);
      req_valid[i] = 1'b1;
      req_dst[i]   = d;
      req_data[i]  = v;
      @(posedge clk);
      #1 req_valid[i] = 1'b0;
   endtask

   initial begin
      for (int i = 0; i < 2; i++) begin
         for (int j = 0; j < 4; j++) regs[i][j] = 4'h0;
         acc[i] = 0; len_m[i] = 0; dst_m[i] = 0;
         act_m[i] = 0; bad_m[i] = 0; err_m[i] = 0; bus_m[i] = 4'h0;
         req_valid[i] = 1'b0; req_dst[i] = 2'd0; req_data[i] = 4'h0;
      end
      fault = 1'b0;

      // Reset held with a request pending
      reset = 1'b0;
      req_valid[0] = 1'b1; req_dst[0] = 2'd2; req_data[0] = 4'hA;
      repeat (3) @(negedge clk);
      chk("rst_ld_n", 32'(ldn0), 32'hF);
      chk("rst_ready", 32'(rdy0), 32'h0);
      chk("rst_done", 32'(done0), 32'h0);
      chk("rst_bus", 32'(bus0), 32'h0);

      // Single write dst=2 data=A
      @(posedge clk); #1 reset = 1'b1;
      @(posedge clk); #1 req_valid[0] = 1'b0;
      @(negedge clk); chk("w1_bus_c1", 32'(bus0), 32'hA);
      chk("w1_ld_c1", 32'(ldn0), 32'hF);
      @(negedge clk); chk("w1_ld_c2", 32'(ldn0), 32'hB);
      @(negedge clk); chk("w1_reg2", 32'(regs[0][2]), 32'hA);
      @(negedge clk); chk("w1_done", 32'(done0), 32'h1);
      chk("w1_err", 32'(err0), 32'h0);
      chk("w1_ready", 32'(rdy0), 32'h1);

      // Back-to-back, second accepted in the done cycle
      req_valid[0] = 1'b1; req_dst[0] = 2'd0; req_data[0] = 4'h3;
      @(posedge clk); #1 req_dst[0] = 2'd3; req_data[0] = 4'hC;
      @(negedge clk);
      @(negedge clk); chk("b2b_ld_a", 32'(ldn0), 32'hE);
      @(negedge clk);
      @(negedge clk); chk("b2b_done_a", 32'({done0, err0}), 32'h2);
      @(posedge clk); #1 req_valid[0] = 1'b0;
      @(negedge clk);
      @(negedge clk); chk("b2b_ld_b", 32'(ldn0), 32'h7);
      @(negedge clk);
      @(negedge clk); chk("b2b_done_b", 32'({done0, err0}), 32'h2);
      chk("b2b_regs", 32'({regs[0][3], regs[0][0]}), 32'hC3);

      // Readback fault on reg1
      fault = 1'b1;
      go(0, 2'd1, 4'h5);
      repeat (4) @(negedge clk);
      chk("flt_done_err", 32'({done0, err0}), 32'h3);
      chk("flt_reg1", 32'(regs[0][1]), 32'h0);
      fault = 1'b0;

      // NUM_REGS=3 bad destination, then a normal no-setup/no-verify write
      go(1, 2'd3, 4'h9);
      @(negedge clk);
      chk("bad_done_err", 32'({done1, err1}), 32'h3);
      chk("bad_ld_n", 32'(ldn1b), 32'h7);
      chk("bad_bus", 32'(bus1), 32'h9);
      go(1, 2'd1, 4'h7);
      @(negedge clk); chk("fast_ld", 32'(ldn1b), 32'h5);
      @(negedge clk); chk("fast_done_err", 32'({done1, err1}), 32'h2);
      chk("fast_reg1", 32'(regs[1][1]), 32'h7);

      // Reset during STROBE aborts the write
      go(0, 2'd2, 4'h6);
      @(negedge clk);
      @(posedge clk); #1 reset = 1'b0;
      @(negedge clk); chk("abt_ld_n", 32'(ldn0), 32'hF);
      @(posedge clk); #1 reset = 1'b1;
      @(negedge clk); chk("abt_idle", 32'({busy0, done0}), 32'h0);
      chk("abt_reg2", 32'(regs[0][2]), 32'hA);
      go(0, 2'd2, 4'h6);
      repeat (4) @(negedge clk);
      chk("post_done_err", 32'({done0, err0}), 32'h2);
      chk("post_reg2", 32'(regs[0][2]), 32'h6);

      repeat (3) @(negedge clk);
      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule
